// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic grid sequencer.
// Included by the top-level sequencer and by the skew-feed lanes.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam int DEF_W = 8;

  // Number of cycles needed to push every skewed operand into an N x N grid.
  function automatic int FEED_LEN(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int IDX_W(input int n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/systolic_skew_feed.sv
// Registered skewed edge lanes for one operand tile: lane l carries element
// (l, t-l) (row-major mode) or (t-l, l) (column mode), zero outside the window.
module systolic_skew_feed
  import systolic_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = DEF_W,
  parameter int TW        = 4,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TW-1:0]    t,
  input  logic [N*N*W-1:0] tile,
  output logic [N*W-1:0]   lanes
);

  logic [N*W-1:0] lanes_d;

  // Lane l only sees data while 0 <= t-l < N; everything else is driven to 0.
  always_comb begin
    lanes_d = '0;
    for (int l = 0; l < N; l++) begin
      if (load && (int'(t) >= l) && (int'(t) - l < N)) begin
        if (COL_MAJOR) begin
          lanes_d[l*W +: W] = tile[((int'(t) - l) * N + l) * W +: W];
        end else begin
          lanes_d[l*W +: W] = tile[(l * N + int'(t) - l) * W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes <= '0;
    end else begin
      lanes <= lanes_d;
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N systolic MAC grid: holds A/B tiles, clears the grid,
// streams skewed operands, waits for flush, then drains results one by one.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int W      = DEF_W,
  parameter  int PE_LAT = 1,
  localparam int AW     = IDX_W(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  output logic             wr_err,
  output logic [N*W-1:0]   a_feed,
  output logic [N*W-1:0]   b_feed,
  output logic             pe_clr,
  output logic             pe_en,
  input  logic [N*N*W-1:0] pe_val,
  output logic [W-1:0]     out_data,
  output logic [AW-1:0]    out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output state_e           dbg_state
);

  localparam int FEED_CYCLES = FEED_LEN(N);
  localparam int TW          = $clog2(FEED_CYCLES);
  localparam int FW          = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  localparam logic [TW-1:0] LAST_T  = TW'(FEED_CYCLES - 1);
  localparam logic [FW-1:0] LAST_FL = FW'(PE_LAT - 1);
  localparam logic [AW-1:0] LAST_K  = AW'(N * N - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [FW-1:0]    fl_q, fl_d;
  logic [AW-1:0]    k_q, k_d;
  logic [N*N*W-1:0] a_buf, b_buf;
  logic             done_q, wr_err_q;
  logic             accept;
  logic             feed_ld;

  // Result stream: a transfer happens on any rising edge where out_valid and
  // out_ready are both high; out_data/out_idx stay frozen until that edge.
  assign accept  = (state_q == DRAIN) && out_ready;
  assign feed_ld = (state_d == FEED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      t_q      <= '0;
      fl_q     <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      fl_q     <= fl_d;
      k_q      <= k_d;
      done_q   <= accept && (k_q == LAST_K);
      wr_err_q <= wr_en && (state_q != IDLE);
    end
  end

  // Tile buffers survive reset; only IDLE-time writes land.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      if (wr_sel) begin
        b_buf[int'(wr_addr) * W +: W] <= wr_data;
      end else begin
        a_buf[int'(wr_addr) * W +: W] <= wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    fl_d    = fl_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = FEED;
        t_d     = '0;
      end
      FEED: begin
        if (t_q == LAST_T) begin
          state_d = FLUSH;
          t_d     = '0;
          fl_d    = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      FLUSH: begin
        if (fl_q == LAST_FL) begin
          state_d = DRAIN;
          fl_d    = '0;
          k_d     = '0;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (k_q == LAST_K) begin
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The lanes are loaded with the next cycle's t so they line up with FEED.
  systolic_skew_feed #(
    .N(N), .W(W), .TW(TW), .COL_MAJOR(1'b0)
  ) u_a_feed (
    .clk   (clk),
    .rst   (rst),
    .load  (feed_ld),
    .t     (t_d),
    .tile  (a_buf),
    .lanes (a_feed)
  );

  systolic_skew_feed #(
    .N(N), .W(W), .TW(TW), .COL_MAJOR(1'b1)
  ) u_b_feed (
    .clk   (clk),
    .rst   (rst),
    .load  (feed_ld),
    .t     (t_d),
    .tile  (b_buf),
    .lanes (b_feed)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign wr_err    = wr_err_q;
  assign pe_clr    = (state_q == CLEAR);
  assign pe_en     = (state_q == FEED) || (state_q == FLUSH);
  assign out_valid = (state_q == DRAIN);
  assign out_idx   = k_q;
  assign out_data  = out_valid ? pe_val[int'(k_q) * W +: W] : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural N x N MAC grid
// that consumes the feeds and supplies pe_val.
module tb_systolic_seq_ctrl;
  import systolic_pkg::*;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int PE_LAT = 1;
  localparam int AW     = 4;
  localparam int NN     = N * N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, wr_err, pe_clr, pe_en, out_valid;
  logic             wr_en = 1'b0;
  logic             wr_sel = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [W-1:0]     wr_data = '0;
  logic [N*W-1:0]   a_feed, b_feed;
  logic [N*N*W-1:0] pe_val;
  logic [W-1:0]     out_data;
  logic [AW-1:0]    out_idx;
  logic             out_ready = 1'b0;
  state_e           dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] ta [NN];
  logic [W-1:0] tb [NN];
  logic [W-1:0] exp_v [NN];

  systolic_seq_ctrl #(.N(N), .W(W), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .a_feed(a_feed), .b_feed(b_feed), .pe_clr(pe_clr),
    .pe_en(pe_en), .pe_val(pe_val), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural grid ----------------
  logic [W-1:0] acc [N][N];
  logic [W-1:0] ar  [N][N];
  logic [W-1:0] br  [N][N];
  logic [W-1:0] ai, bi;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ai = (j == 0) ? a_feed[i*W +: W] : ar[i][(j == 0) ? 0 : j - 1];
        bi = (i == 0) ? b_feed[j*W +: W] : br[(i == 0) ? 0 : i - 1][j];
        if (pe_clr) begin
          acc[i][j] <= '0;
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
        end else if (pe_en) begin
          acc[i][j] <= acc[i][j] + W'(ai * bi);
          ar[i][j]  <= ai;
          br[i][j]  <= bi;
        end
      end
    end
  end

  always_comb begin
    pe_val = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        pe_val[(i*N + j)*W +: W] = acc[i][j];
  end

  // ---------------- driver tasks ----------------
  task automatic load_tiles(input bit do_a, input bit do_b);
    for (int s = 0; s < 2; s++) begin
      if ((s == 0 && do_a) || (s == 1 && do_b)) begin
        for (int e = 0; e < NN; e++) begin
          wr_en   = 1'b1;
          wr_sel  = (s == 1);
          wr_addr = AW'(e);
          wr_data = (s == 0) ? ta[e] : tb[e];
          @(negedge clk);
        end
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic start_run(input bit with_wr, input logic [AW-1:0] addr, input logic [W-1:0] d);
    start   = 1'b1;
    wr_en   = with_wr;
    wr_sel  = 1'b0;
    wr_addr = addr;
    wr_data = d;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    n_checks++; if (pe_clr !== 1'b1) $display("FAIL clear_pe_clr got=%0b exp=1", pe_clr); else n_pass++;
    n_checks++; if (dbg_state !== CLEAR) $display("FAIL clear_state got=%0d exp=%0d", dbg_state, CLEAR); else n_pass++;
    n_checks++; if (wr_err !== 1'b0) $display("FAIL clear_wr_err got=%0b exp=0", wr_err); else n_pass++;
  endtask

  // Called at the CLEAR negedge when check_counts is set.
  task automatic wait_drain(input bit check_counts);
    int n = 0, en_cnt = 0, clr_cnt = 0;
    while (!out_valid && n < 60) begin
      if (pe_en) en_cnt++;
      if (pe_clr) clr_cnt++;
      @(negedge clk);
      n++;
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_timeout got=%0b exp=1", out_valid); else n_pass++;
    if (check_counts) begin
      n_checks++; if (en_cnt != FEED_LEN(N) + PE_LAT) $display("FAIL pe_en_cycles got=%0d exp=%0d", en_cnt, FEED_LEN(N) + PE_LAT); else n_pass++;
      n_checks++; if (clr_cnt != 1) $display("FAIL pe_clr_cycles got=%0d exp=1", clr_cnt); else n_pass++;
      n_checks++; if (n != 2 + FEED_LEN(N)) $display("FAIL clear_to_drain got=%0d exp=%0d", n, 2 + FEED_LEN(N)); else n_pass++;
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic drain(input int mode);
    int k = 0, cyc = 0;
    bit rdy;
    while (k < NN && cyc < 200) begin
      rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      out_ready = rdy;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid k=%0d got=%0b exp=1", k, out_valid); else n_pass++;
      n_checks++; if (out_idx !== AW'(k)) $display("FAIL drain_idx got=%0d exp=%0d", out_idx, k); else n_pass++;
      n_checks++; if (out_data !== exp_v[k]) $display("FAIL drain_data k=%0d got=%0d exp=%0d", k, out_data, exp_v[k]); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL early_done k=%0d got=%0b exp=0", k, done); else n_pass++;
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    out_ready = 1'b0;
    n_checks++; if (k != NN) $display("FAIL drain_count got=%0d exp=%0d", k, NN); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL done_pulse got=%0b exp=1", done); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL valid_after_last got=%0b exp=0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_after_last got=%0b exp=0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL done_width got=%0b exp=0", done); else n_pass++;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++; if (dbg_state !== IDLE) $display("FAIL %s_state got=%0d exp=0", tag, dbg_state); else n_pass++;
    n_checks++; if ({busy, done, wr_err, pe_clr, pe_en, out_valid} !== 6'b0)
      $display("FAIL %s_ctrl got=%b exp=000000", tag, {busy, done, wr_err, pe_clr, pe_en, out_valid}); else n_pass++;
    n_checks++; if ({a_feed, b_feed} !== '0) $display("FAIL %s_feeds got=%h exp=0", tag, {a_feed, b_feed}); else n_pass++;
    n_checks++; if ({out_data, out_idx} !== '0) $display("FAIL %s_out got=%h exp=0", tag, {out_data, out_idx}); else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
  endtask

  task automatic test_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ta[r*N + c] = (r == c) ? 8'd1 : 8'd0;
        tb[r*N + c] = W'(r*4 + c + 1);
      end
    load_tiles(1'b1, 1'b1);
    start_run(1'b0, '0, '0);
    wait_drain(1'b1);
    for (int e = 0; e < NN; e++) exp_v[e] = W'(e + 1);
    drain(0);
  endtask

  task automatic test_skew();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) ta[r*N + c] = W'(16*r + c);
    load_tiles(1'b1, 1'b0);
    start_run(1'b0, '0, '0);
    n_checks++; if (a_feed !== 32'h0) $display("FAIL skew_clear_a got=%h exp=0", a_feed); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (a_feed !== 32'h00001001) $display("FAIL skew_t1_a got=%h exp=00001001", a_feed); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (a_feed !== 32'h30211203) $display("FAIL skew_t3_a got=%h exp=30211203", a_feed); else n_pass++;
    n_checks++; if (b_feed !== 32'h04070a0d) $display("FAIL skew_t3_b got=%h exp=04070a0d", b_feed); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (a_feed !== 32'h33000000) $display("FAIL skew_t6_a got=%h exp=33000000", a_feed); else n_pass++;
    n_checks++; if (b_feed !== 32'h10000000) $display("FAIL skew_t6_b got=%h exp=10000000", b_feed); else n_pass++;
    @(negedge clk);
    n_checks++; if (a_feed !== 32'h0) $display("FAIL skew_t7_a got=%h exp=0", a_feed); else n_pass++;
    n_checks++; if (pe_en !== 1'b1) $display("FAIL skew_t7_pe_en got=%0b exp=1", pe_en); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all23();
    for (int e = 0; e < NN; e++) begin
      ta[e] = 8'd2;
      tb[e] = 8'd3;
      exp_v[e] = 8'd24;
    end
    load_tiles(1'b1, 1'b1);
    start_run(1'b0, '0, '0);
    wait_drain(1'b1);
    drain(0);
  endtask

  task automatic test_back_pressure();
    start_run(1'b0, '0, '0);
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'hff; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    n_checks++; if (wr_err !== 1'b1) $display("FAIL busy_wr_err got=%0b exp=1", wr_err); else n_pass++;
    n_checks++; if (dbg_state !== FEED) $display("FAIL start_in_feed got=%0d exp=%0d", dbg_state, FEED); else n_pass++;
    @(negedge clk);
    n_checks++; if (wr_err !== 1'b0) $display("FAIL wr_err_width got=%0b exp=0", wr_err); else n_pass++;
    wait_drain(1'b0);
    drain(1);
  endtask

  task automatic test_reset_mid_run();
    start_run(1'b0, '0, '0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got=%0b exp=0", done); else n_pass++;
    start_run(1'b0, '0, '0);
    wait_drain(1'b1);
    drain(0);
  endtask

  task automatic test_start_with_write();
    start_run(1'b1, '0, 8'd5);
    wait_drain(1'b1);
    for (int e = 0; e < NN; e++) exp_v[e] = (e < N) ? 8'd33 : 8'd24;
    drain(0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_all23();
    test_back_pressure();
    test_reset_mid_run();
    test_start_with_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
